down_counter: RTL and testbench
===============================

Name: down_counter

Overview:
- Loadable, pausable down-counter for the tablet filling machine.
- Counts remaining tablets or seconds toward zero, one decrement per `enable` tick.
- Emits a one-cycle `borrow_out` pulse on the tick that reaches zero.
- Complements the existing up-counter: it drives "remaining" displays and end-of-batch detection, while the up-counter drives the elapsed/filled side.

Parameters:
- WIDTH, 32, width of `set_count` and `count`.
- MAX_COUNT, 59, upper bound of `count`. Loads above it saturate to it. It is also the reload value on restart and on wrap.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- set  input  1  synchronous load of `set_count`; highest-priority control.
- set_count  input  WIDTH  value loaded by `set`.
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- enable  input  1  decrement tick; acted on only in RUN.
- count  output  WIDTH  current remaining value (registered).
- borrow_out  output  1  one-cycle pulse, registered, on the tick that takes `count` from 1 to 0.
- zero  output  1  registered flag; high whenever `count` == 0.
- state  output  2  FSM state: IDLE=0, RUN=1, HOLD=2, DONE=3.

Behaviour:
- Reset (`reset_n` low, asynchronous, any state):
  - `count`=0, `borrow_out`=0, `zero`=1, `state`=IDLE.
  - Takes effect immediately, including mid-count.
  - Release is synchronous to the next `clk` edge.
- Priority per cycle: `set` > `start` > `pause` > `enable`. Only the highest active control acts.
- `borrow_out` defaults to 0 every cycle. It is high only in the cycle after the qualifying tick. It is never high for two consecutive cycles.
- `set` (any state):
  - `count` <= `set_count` if `set_count` <= MAX_COUNT, else MAX_COUNT.
  - `state` <= IDLE.
  - `zero` <= (loaded value == 0).
  - `borrow_out` <= 0.
- `start`:
  - IDLE with `count`≠0 → RUN.
  - IDLE with `count`==0 → DONE; no `borrow_out` pulse.
  - HOLD → RUN.
  - DONE → `count` <= MAX_COUNT, `zero` <= 0, RUN.
  - RUN → no effect.
  - Never decrements in the same cycle.
- `pause`: RUN → HOLD. Ignored in IDLE, HOLD and DONE. `count` is frozen in HOLD.
- `enable` in RUN:
  - `count`≥2: `count` <= `count`−1.
  - `count`==1: `count` <= 0, `zero` <= 1, `borrow_out` <= 1, `state` <= DONE.
  - `count`==0: only reachable with the optional feature (see below).
- `enable` in IDLE, HOLD or DONE: ignored; `count` unchanged.
- Arithmetic: unsigned, WIDTH bits. `count` never underflows. MAX_COUNT must fit in WIDTH.
- Simultaneous `set` and `enable` on the tick that would reach zero: `set` wins, no pulse.
- Simultaneous `pause` and `enable`: `pause` wins, no decrement.

Optional Feature:
- Macro: DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - RUN never enters DONE.
  - On `enable` at `count`==1: `count` <= 0, `zero` <= 1, `borrow_out` pulse, stay in RUN.
  - Next `enable` at `count`==0: `count` <= MAX_COUNT, `zero` <= 0, no pulse.
  - Gives continuous modulo-(MAX_COUNT+1) down-counting.
  - `start` in IDLE with `count`==0 → RUN.
- Undefined: behaviour exactly as in Behaviour. DONE is sticky until `set` or `start`.

Test Plan:
- Reset: assert `reset_n`=0 mid-count at `count`=17 → asynchronously `count`=0, `zero`=1, `state`=IDLE, `borrow_out`=0.
- Load and countdown: `set` with `set_count`=3, `start`, then 3 `enable` ticks → `count` 3,2,1,0; `borrow_out` high exactly one cycle with `count`=0; `state`=DONE; further `enable` leaves `count`=0.
- Saturation and restart: `set` with `set_count`=100 (MAX_COUNT=59) → `count`=59. `start` from DONE → `count`=59, RUN.
- Pause: RUN at `count`=10, `pause` with `enable` held 5 cycles → `count` stays 10, HOLD. `start` then 2 ticks → `count`=8.
- Priority: at `count`=1 in RUN, drive `set`(`set_count`=5) together with `enable` → `count`=5, IDLE, no `borrow_out`.
- Zero start: `set` with `set_count`=0, `start` → DONE, no pulse. With DOWN_COUNTER_AUTO_RELOAD_EN: → RUN; next `enable` → `count`=59, no pulse.

Source files
------------

// File: rtl/down_counter_if.sv
// ============================================================================
// Module   : down_counter_if
// Brief    : Control/status bundle between a controller and down_counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface down_counter_if #(
    parameter int WIDTH = 32
);
    logic             set;
    logic [WIDTH-1:0] set_count;
    logic             start;
    logic             pause;
    logic             enable;
    logic [WIDTH-1:0] count;
    logic             borrow_out;
    logic             zero;
    logic [1:0]       state;

    modport master (
        output set, set_count, start, pause, enable,
        input  count, borrow_out, zero, state
    );

    modport slave (
        input  set, set_count, start, pause, enable,
        output count, borrow_out, zero, state
    );
endinterface

`default_nettype wire

// File: rtl/down_counter.sv
// ============================================================================
// Module   : down_counter
// Brief    : Loadable, pausable down-counter with one-cycle borrow pulse.
//            Optional macro DOWN_COUNTER_AUTO_RELOAD_EN gives modulo wrap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module down_counter #(
    parameter int WIDTH     = 32,
    parameter int MAX_COUNT = 59
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    down_counter_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             zero_q,  zero_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] load_val;

    assign load_val = (bus.set_count > C_MAX) ? C_MAX : bus.set_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            count_q  <= C_ZERO;
            zero_q   <= 1'b1;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            zero_q   <= zero_d;
            borrow_q <= borrow_d;
        end
    end

    // Only the highest-priority active control acts: set > start > pause > enable.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        zero_d   = zero_q;
        borrow_d = 1'b0;

        if (bus.set) begin
            count_d = load_val;
            zero_d  = (load_val == C_ZERO);
            state_d = S_IDLE;
        end else if (bus.start) begin
            case (state_q)
                S_IDLE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                    state_d = S_RUN;
`else
                    state_d = (count_q != C_ZERO) ? S_RUN : S_DONE;
`endif
                end
                S_HOLD: state_d = S_RUN;
                S_DONE: begin
                    count_d = C_MAX;
                    zero_d  = (C_MAX == C_ZERO);
                    state_d = S_RUN;
                end
                default: state_d = state_q;
            endcase
        end else if (bus.pause) begin
            if (state_q == S_RUN) begin
                state_d = S_HOLD;
            end
        end else if (bus.enable && (state_q == S_RUN)) begin
            if (count_q == C_ONE) begin
                count_d  = C_ZERO;
                zero_d   = 1'b1;
                borrow_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                state_d  = S_RUN;
`else
                state_d  = S_DONE;
`endif
            end else if (count_q == C_ZERO) begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                count_d = C_MAX;
                zero_d  = (C_MAX == C_ZERO);
`else
                count_d = C_ZERO;
`endif
            end else begin
                count_d = count_q - C_ONE;
            end
        end
    end

    assign bus.count      = count_q;
    assign bus.zero       = zero_q;
    assign bus.borrow_out = borrow_q;
    assign bus.state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_down_counter.sv
// ============================================================================
// Module   : tb_down_counter
// Brief    : Directed scoreboard bench for down_counter (WIDTH=32, MAX_COUNT=59).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_down_counter;

    localparam int WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct {
        logic [31:0] cnt;
        logic        bo;
        logic        z;
        logic [1:0]  st;
        string       tag;
    } exp_t;

    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;
    exp_t sb[$];

    down_counter_if #(.WIDTH(WIDTH)) bus ();

    down_counter #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (59)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".count"},  bus.count,               e.cnt);
            chk({e.tag, ".borrow"}, {31'd0, bus.borrow_out}, {31'd0, e.bo});
            chk({e.tag, ".zero"},   {31'd0, bus.zero},       {31'd0, e.z});
            chk({e.tag, ".state"},  {30'd0, bus.state},      {30'd0, e.st});
        end
    endtask

    task automatic expect_now(input logic [31:0] ec, input logic eb, input logic ez,
                              input logic [1:0] es, input string tag);
        sb.push_back('{cnt: ec, bo: eb, z: ez, st: es, tag: tag});
        compare_out();
    endtask

    task automatic step(input logic s, input logic [31:0] sc, input logic st,
                        input logic p, input logic en,
                        input logic [31:0] ec, input logic eb, input logic ez,
                        input logic [1:0] es, input string tag);
        bus.set       = s;
        bus.set_count = sc;
        bus.start     = st;
        bus.pause     = p;
        bus.enable    = en;
        sb.push_back('{cnt: ec, bo: eb, z: ez, st: es, tag: tag});
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset_n       = 1'b0;
        bus.set       = 1'b0;
        bus.set_count = '0;
        bus.start     = 1'b0;
        bus.pause     = 1'b0;
        bus.enable    = 1'b0;

        #12;
        expect_now(0, 0, 1, ST_IDLE, "reset");
        reset_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 1, ST_IDLE, "post_reset");

        // Load and countdown to zero
        step(1, 3, 0, 0, 0, 3, 0, 0, ST_IDLE, "load3");
        step(0, 0, 1, 0, 0, 3, 0, 0, ST_RUN,  "start3");
        step(0, 0, 0, 0, 1, 2, 0, 0, ST_RUN,  "tick2");
        step(0, 0, 0, 0, 1, 1, 0, 0, ST_RUN,  "tick1");
        step(0, 0, 0, 0, 1, 0, 1, 1, ST_DONE, "tick0");
        step(0, 0, 0, 0, 1, 0, 0, 1, ST_DONE, "done_en1");
        step(0, 0, 0, 0, 1, 0, 0, 1, ST_DONE, "done_en2");

        // Restart from DONE, then saturating load
        step(0, 0, 1, 0, 0, 59, 0, 0, ST_RUN,  "restart");
        step(0, 0, 0, 0, 1, 58, 0, 0, ST_RUN,  "restart_tick");
        step(1, 100, 0, 0, 0, 59, 0, 0, ST_IDLE, "sat100");
        step(1, 60, 0, 0, 0, 59, 0, 0, ST_IDLE, "sat60");
        step(1, 59, 0, 0, 0, 59, 0, 0, ST_IDLE, "load59");
        step(0, 0, 0, 1, 1, 59, 0, 0, ST_IDLE, "idle_pause_en");

        // Pause with enable held
        step(1, 10, 0, 0, 0, 10, 0, 0, ST_IDLE, "load10");
        step(0, 0, 1, 0, 0, 10, 0, 0, ST_RUN,  "start10");
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 1, 1, 10, 0, 0, ST_HOLD, "pause_en");
        step(0, 0, 0, 0, 1, 10, 0, 0, ST_HOLD, "hold_en");
        step(0, 0, 1, 0, 1, 10, 0, 0, ST_RUN,  "resume");
        step(0, 0, 1, 0, 1, 10, 0, 0, ST_RUN,  "start_in_run");
        step(0, 0, 0, 0, 1, 9, 0, 0, ST_RUN,   "tick9");
        step(0, 0, 0, 0, 1, 8, 0, 0, ST_RUN,   "tick8");

        // Count down to 1, then set beats the zero-reaching tick
        for (int i = 7; i >= 1; i--)
            step(0, 0, 0, 0, 1, i, 0, 0, ST_RUN, "run_down");
        step(1, 5, 0, 0, 1, 5, 0, 0, ST_IDLE, "set_vs_en");
        step(0, 0, 0, 0, 1, 5, 0, 0, ST_IDLE, "idle_en");

        // Start with count already zero
        step(1, 0, 0, 0, 0, 0, 0, 1, ST_IDLE, "load0");
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        step(0, 0, 1, 0, 0, 0, 0, 1, ST_RUN,  "start0");
        step(0, 0, 0, 0, 1, 59, 0, 0, ST_RUN, "wrap");
        step(1, 1, 0, 0, 0, 1, 0, 0, ST_IDLE, "load1");
        step(0, 0, 1, 0, 0, 1, 0, 0, ST_RUN,  "start1");
        step(0, 0, 0, 0, 1, 0, 1, 1, ST_RUN,  "ar_tick0");
        step(0, 0, 0, 0, 1, 59, 0, 0, ST_RUN, "ar_reload");
`else
        step(0, 0, 1, 0, 0, 0, 0, 1, ST_DONE, "start0");
        step(0, 0, 0, 0, 1, 0, 0, 1, ST_DONE, "start0_en");
`endif

        // Asynchronous reset mid-count at 17
        step(1, 20, 0, 0, 0, 20, 0, 0, ST_IDLE, "load20");
        step(0, 0, 1, 0, 0, 20, 0, 0, ST_RUN,  "start20");
        step(0, 0, 0, 0, 1, 19, 0, 0, ST_RUN,  "t19");
        step(0, 0, 0, 0, 1, 18, 0, 0, ST_RUN,  "t18");
        step(0, 0, 0, 0, 1, 17, 0, 0, ST_RUN,  "t17");
        #2;
        reset_n = 1'b0;
        #1;
        expect_now(0, 0, 1, ST_IDLE, "async_reset");
        step(0, 0, 0, 0, 1, 0, 0, 1, ST_IDLE, "reset_held");
        reset_n = 1'b1;
        step(0, 0, 0, 0, 1, 0, 0, 1, ST_IDLE, "reset_release");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
